// File: rtl/whack_pkg.sv
// Shared definitions for the mole field game: FSM encoding, LFSR constants,
// default sizing and the LFSR step function.
package whack_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam int          DEF_NUM_HOLES = 5;
  localparam int          DEF_SCORE_W   = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/mole_slot.sv
// One hole: up flag plus remaining-lifetime counter. Clear beats hit beats
// spawn; an expiry masked by a hit or a clear does not escape.
module mole_slot
  import whack_pkg::*;
#(
  parameter int LIFE_TICKS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_spawn,
  input  logic i_hit,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_up,
  output logic o_escape
);
  localparam int            LW   = $clog2(LIFE_TICKS + 1);
  localparam logic [LW-1:0] LIFE = LW'(LIFE_TICKS);

  logic          r_up;
  logic [LW-1:0] r_life;

  assign o_up     = r_up;
  assign o_escape = i_tick & r_up & (r_life == LW'(1)) & ~i_hit & ~i_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_up   <= 1'b0;
      r_life <= '0;
    end else if (i_clr || (i_hit && r_up)) begin
      r_up   <= 1'b0;
      r_life <= '0;
    end else if (i_spawn) begin
      r_up   <= 1'b1;
      r_life <= LIFE;
    end else if (i_tick && r_up) begin
      r_life <= r_life - 1'b1;
      if (r_life == LW'(1)) r_up <= 1'b0;
    end
  end
endmodule

// File: rtl/mole_field.sv
// Whack-a-mole game core: tick timer, LFSR-driven spawns, hit detection, score.
// Define MOLE_MISS_PENALTY_EN to make misses and escapes cost one point each.
module mole_field
  import whack_pkg::*;
#(
  parameter  int NUM_HOLES   = DEF_NUM_HOLES,
  parameter  int TICK_CYCLES = 50000000,
  parameter  int GAME_TICKS  = 30,
  parameter  int SPAWN_TICKS = 1,
  parameter  int LIFE_TICKS  = 3,
  parameter  int SCORE_W     = DEF_SCORE_W,
  localparam int HW          = $clog2(NUM_HOLES + 1),
  localparam int TW          = $clog2(GAME_TICKS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [HW-1:0]        hit_sel,
  output logic [NUM_HOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic [TW-1:0]        time_left,
  output logic [1:0]           state,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 escape_pulse
);
  localparam int                 CW   = $clog2(TICK_CYCLES + 1);
  localparam int                 SPW  = $clog2(SPAWN_TICKS + 1);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  state_t             r_state;
  logic [CW-1:0]      r_tick_cnt;
  logic [SPW-1:0]     r_spawn_cnt;
  logic [TW-1:0]      r_time;
  logic [SCORE_W-1:0] r_score;
  logic [15:0]        r_lfsr;
  logic [HW-1:0]      r_hit, r_hit_prev;
  logic               r_hit_p, r_miss_p, r_esc_p;

  logic                 w_run, w_tick, w_last, w_start, w_clr, w_spawn_try;
  logic                 w_hev, w_hit_ok, w_miss, w_esc;
  logic [7:0]           w_hole;
  logic [NUM_HOLES-1:0] w_up, w_hit_vec, w_spawn_vec, w_esc_vec;
  logic [SCORE_W-1:0]   w_score_nxt;

  assign w_run       = (r_state == S_RUN);
  assign w_start     = start && !w_run;
  assign w_tick      = w_run && (r_tick_cnt == CW'(TICK_CYCLES - 1));
  assign w_last      = w_tick && (r_time == TW'(1));
  assign w_clr       = w_last || w_start;
  assign w_spawn_try = w_tick && (r_spawn_cnt == SPW'(SPAWN_TICKS - 1)) && !w_last;
  assign w_hole      = 8'(r_lfsr[7:0] % 8'(NUM_HOLES));
  // A held selector scores once: only a change to a nonzero value is an event
  assign w_hev       = w_run && (r_hit != '0) && (r_hit != r_hit_prev);
  assign w_hit_ok    = |(w_hit_vec & w_up);
  assign w_miss      = w_hev && !w_hit_ok;
  assign w_esc       = |w_esc_vec;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
    assign w_hit_vec[i]   = w_hev && (r_hit == HW'(i + 1));
    assign w_spawn_vec[i] = w_spawn_try && (w_hole == 8'(i)) && !w_up[i] && !w_hit_vec[i];
    mole_slot #(.LIFE_TICKS(LIFE_TICKS)) u_slot (
      .clock   (clock),
      .reset   (reset),
      .i_spawn (w_spawn_vec[i]),
      .i_hit   (w_hit_vec[i]),
      .i_tick  (w_tick),
      .i_clr   (w_clr),
      .o_up    (w_up[i]),
      .o_escape(w_esc_vec[i])
    );
  end

`ifdef MOLE_MISS_PENALTY_EN
  localparam int SXW = SCORE_W + 2;
  logic [SXW-1:0] w_sum;
  always_comb begin
    w_sum = {2'b00, r_score} + SXW'(w_hit_ok) - SXW'(w_miss) - SXW'(w_esc);
    if (w_sum[SXW-1])        w_score_nxt = '0;
    else if (w_sum[SCORE_W]) w_score_nxt = SMAX;
    else                     w_score_nxt = w_sum[SCORE_W-1:0];
  end
`else
  always_comb begin
    w_score_nxt = r_score;
    if (w_hit_ok && (r_score != SMAX)) w_score_nxt = r_score + 1'b1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_spawn_cnt <= '0;
      r_time      <= TW'(GAME_TICKS);
      r_score     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_hit       <= '0;
      r_hit_prev  <= '0;
      r_hit_p     <= 1'b0;
      r_miss_p    <= 1'b0;
      r_esc_p     <= 1'b0;
    end else begin
      r_lfsr     <= lfsr_next(r_lfsr);
      r_hit      <= hit_sel;
      r_hit_prev <= r_hit;
      r_hit_p    <= w_hit_ok;
      r_miss_p   <= w_miss;
      r_esc_p    <= w_esc;
      if (w_start) begin
        r_state     <= S_RUN;
        r_tick_cnt  <= '0;
        r_spawn_cnt <= '0;
        r_time      <= TW'(GAME_TICKS);
        r_score     <= '0;
      end else if (w_run) begin
        r_score    <= w_score_nxt;
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          r_time      <= r_time - 1'b1;
          r_spawn_cnt <= (r_spawn_cnt == SPW'(SPAWN_TICKS - 1)) ? '0 : r_spawn_cnt + 1'b1;
          if (w_last) r_state <= S_OVER;
        end
      end
    end
  end

  assign moles        = w_up;
  assign score        = r_score;
  assign time_left    = r_time;
  assign state        = r_state;
  assign hit_pulse    = r_hit_p;
  assign miss_pulse   = r_miss_p;
  assign escape_pulse = r_esc_p;
endmodule

// File: tb/tb_mole_field.sv
// Bench for mole_field: cycle-level reference model feeding a scoreboard,
// a timing table for one full game, and directed corner-case sequences.
module tb_mole_field;
  localparam int NH = 5, TC = 4, GT = 5, LT = 2, SP = 1, SW = 4, GT2 = 60;
  localparam int HW = $clog2(NH + 1), TW = $clog2(GT + 1), TW2 = $clog2(GT2 + 1);
  localparam int SMAX = (1 << SW) - 1;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, s_start = 1'b0;
  logic [HW-1:0] hit_sel = '0, s_hit = '0;
  logic [NH-1:0] moles, s_moles;
  logic [SW-1:0] score, s_score;
  logic [TW-1:0] time_left;
  logic [TW2-1:0] s_time;
  logic [1:0] state, s_state;
  logic hit_pulse, miss_pulse, escape_pulse, s_hp, s_mp, s_ep;

  always #5 clock = ~clock;

  mole_field #(.NUM_HOLES(NH), .TICK_CYCLES(TC), .GAME_TICKS(GT), .SPAWN_TICKS(SP),
               .LIFE_TICKS(LT), .SCORE_W(SW)) u_dut (
    .clock(clock), .reset(reset), .start(start), .hit_sel(hit_sel), .moles(moles),
    .score(score), .time_left(time_left), .state(state), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .escape_pulse(escape_pulse));

  // Long game used only to reach score saturation
  mole_field #(.NUM_HOLES(NH), .TICK_CYCLES(TC), .GAME_TICKS(GT2), .SPAWN_TICKS(SP),
               .LIFE_TICKS(LT), .SCORE_W(SW)) u_sat (
    .clock(clock), .reset(reset), .start(s_start), .hit_sel(s_hit), .moles(s_moles),
    .score(s_score), .time_left(s_time), .state(s_state), .hit_pulse(s_hp),
    .miss_pulse(s_mp), .escape_pulse(s_ep));

  typedef struct packed {
    logic [1:0] st; logic [TW-1:0] tl; logic [SW-1:0] sc; logic [NH-1:0] mo;
    logic hp, mp, ep;
  } obs_t;
  obs_t sbq[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model state
  int m_state, m_tcnt, m_scnt, m_time, m_score, m_hit, m_hprev;
  bit [15:0] m_lfsr;
  bit m_up[NH];
  int m_life[NH];
  bit m_hp, m_mp, m_ep;

  function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
    bit lsb = s[0];
    s = s >> 1;
    if (lsb) begin s[15] ^= 1'b1; s[13] ^= 1'b1; s[12] ^= 1'b1; s[10] ^= 1'b1; end
    return s;
  endfunction

  task automatic mreset();
    m_state = 0; m_tcnt = 0; m_scnt = 0; m_time = GT; m_score = 0;
    m_hit = 0; m_hprev = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < NH; i++) begin m_up[i] = 0; m_life[i] = 0; end
    m_hp = 0; m_mp = 0; m_ep = 0;
  endtask

  task automatic mstep(input bit st_in, input int hs);
    bit run, tick, last, ev, hit, miss, esc, sp, entry;
    int tgt, hole, sc;
    run  = (m_state == 1);
    tick = run && (m_tcnt == TC - 1);
    last = tick && (m_time == 1);
    ev   = run && (m_hit != 0) && (m_hit != m_hprev);
    tgt  = m_hit - 1;
    hit = 0; miss = 0; esc = 0;
    if (ev) begin
      if (m_hit <= NH && m_up[tgt]) hit = 1; else miss = 1;
    end
    hole  = int'(m_lfsr[7:0]) % NH;
    sp    = tick && (m_scnt == SP - 1) && !last && !m_up[hole] && !(ev && tgt == hole);
    entry = st_in && !run;
    for (int i = 0; i < NH; i++) begin
      if (entry || last) begin m_up[i] = 0; m_life[i] = 0; end
      else if (hit && i == tgt) begin m_up[i] = 0; m_life[i] = 0; end
      else if (tick && m_up[i]) begin
        m_life[i]--;
        if (m_life[i] == 0) begin m_up[i] = 0; esc = 1; end
      end
    end
    if (sp) begin m_up[hole] = 1; m_life[hole] = LT; end
    sc = m_score;
`ifdef MOLE_MISS_PENALTY_EN
    sc = sc + int'(hit) - int'(miss) - int'(esc);
    if (sc < 0) sc = 0;
    if (sc > SMAX) sc = SMAX;
`else
    if (hit && sc < SMAX) sc++;
`endif
    if (entry) begin
      m_state = 1; m_tcnt = 0; m_scnt = 0; m_time = GT; m_score = 0;
    end else if (run) begin
      m_score = sc;
      if (tick) begin
        m_tcnt = 0; m_time--;
        m_scnt = (m_scnt == SP - 1) ? 0 : m_scnt + 1;
        if (m_time == 0) m_state = 2;
      end else m_tcnt++;
    end
    m_hp = hit; m_mp = miss; m_ep = esc;
    m_lfsr = lfsr_adv(m_lfsr);
    m_hprev = m_hit; m_hit = hs;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // One clock: model predicts, DUT output compared one edge later
  task automatic cycle();
    obs_t e, a;
    mstep(start, int'(hit_sel));
    e.st = 2'(m_state); e.tl = TW'(m_time); e.sc = SW'(m_score);
    for (int i = 0; i < NH; i++) e.mo[i] = m_up[i];
    e.hp = m_hp; e.mp = m_mp; e.ep = m_ep;
    sbq.push_back(e);
    @(posedge clock); #1;
    e = sbq.pop_front();
    a = {state, time_left, score, moles, hit_pulse, miss_pulse, escape_pulse};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t: got st=%0d tl=%0d sc=%0d mo=%b p=%b%b%b, expected st=%0d tl=%0d sc=%0d mo=%b p=%b%b%b",
               $time, a.st, a.tl, a.sc, a.mo, a.hp, a.mp, a.ep, e.st, e.tl, e.sc, e.mo, e.hp, e.mp, e.ep);
    end
    @(negedge clock);
  endtask

  // Called just after a falling edge; returns before the next rising edge
  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    mreset();
    sbq.delete();
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_score"}, int'(score), 0);
    chk({nm, "_moles"}, int'(moles), 0);
    chk({nm, "_time"}, int'(time_left), GT);
    chk({nm, "_pulses"}, int'({hit_pulse, miss_pulse, escape_pulse}), 0);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit st; int hs; int n; int exp_st; int exp_tl; int exp_mcnt; int exp_ep; int exp_sc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int h, nh, m2, np, hits;
    tbl[0] = '{1, 0, 1, 1, 5,  0,  0, 0};
    tbl[1] = '{0, 0, 4, 1, 4,  1,  0, 0};
    tbl[2] = '{0, 0, 4, 1, 3, -1,  0, 0};
    tbl[3] = '{0, 0, 4, 1, 2, -1,  1, 0};
    tbl[4] = '{0, 0, 4, 1, 1, -1, -1, 0};
    tbl[5] = '{0, 0, 4, 2, 0,  0, -1, 0};
    tbl[6] = '{0, 0, 3, 2, 0,  0,  0, 0};

    @(negedge clock);
    do_reset("rst");
    repeat (2) cycle();

    // Full game timing, first spawn and its escape
    h = 0;
    for (int v = 0; v < 7; v++) begin
      start = tbl[v].st; hit_sel = HW'(tbl[v].hs);
      repeat (tbl[v].n) begin cycle(); start = 1'b0; end
      chk($sformatf("tbl%0d_state", v), int'(state), tbl[v].exp_st);
      chk($sformatf("tbl%0d_time", v), int'(time_left), tbl[v].exp_tl);
      chk($sformatf("tbl%0d_score", v), int'(score), tbl[v].exp_sc);
      if (tbl[v].exp_mcnt >= 0) chk($sformatf("tbl%0d_mcnt", v), $countones(moles), tbl[v].exp_mcnt);
      if (tbl[v].exp_ep >= 0) chk($sformatf("tbl%0d_esc", v), int'(escape_pulse), tbl[v].exp_ep);
      if (v == 1) for (int i = NH - 1; i >= 0; i--) if (moles[i]) h = i;
      if (v == 3) chk("esc_hole_cleared", int'(moles[h]), 0);
    end

    // Wait for a mole in hole 2, then hold hit_sel=3
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 3000 && !m_up[2]; k++) begin
      if (m_state == 2) start = 1'b1;
      cycle(); start = 1'b0;
    end
    chk("spawn2_seen", int'(moles[2]), 1);
    hit_sel = 3'd3; nh = 0; m2 = 1;
    repeat (10) begin
      cycle();
      if (hit_pulse) begin nh++; m2 = int'(moles[2]); end
    end
    chk("held_hit_count", nh, 1);
    chk("held_hit_cleared", m2, 0);
`ifndef MOLE_MISS_PENALTY_EN
    chk("held_hit_score", int'(score), 1);
`endif
    hit_sel = '0;
    for (int k = 0; k < 200 && m_state != 2; k++) cycle();
    chk("game2_over", int'(state), 2);

    // Hit lands on the expiry edge of the first mole
    start = 1'b1; cycle(); start = 1'b0;
    repeat (4) cycle();
    chk("g3_first_spawn", $countones(moles), 1);
    h = 0;
    for (int i = NH - 1; i >= 0; i--) if (moles[i]) h = i;
    repeat (6) cycle();
    hit_sel = HW'(h + 1); cycle();
    hit_sel = '0; cycle();
    chk("exp_hit_pulse", int'(hit_pulse), 1);
    chk("exp_hit_noesc", int'(escape_pulse), 0);
    chk("exp_hit_cleared", int'(moles[h]), 0);
    chk("exp_hit_score", int'(score), 1);
    cycle();

    // Reset in the middle of a game
    chk("pre_reset_run", int'(state), 1);
    do_reset("midrst");
    np = 0;
    repeat (3) begin cycle(); np += int'(hit_pulse | miss_pulse | escape_pulse); end
    chk("post_reset_pulses", np, 0);

    // Misses at score 0: out-of-range selector, then an empty hole
    start = 1'b1; cycle(); start = 1'b0;
    hit_sel = 3'd7; cycle();
    hit_sel = '0; cycle();
    chk("miss_oor_pulse", int'(miss_pulse), 1);
    chk("miss_oor_score", int'(score), 0);
    hit_sel = 3'd1; cycle();
    hit_sel = '0; cycle();
    chk("miss_empty_pulse", int'(miss_pulse), 1);
    chk("miss_empty_score", int'(score), 0);
    chk("miss_blocks_spawn", int'(moles[0]), 0);

    // Score saturation on the long-game instance
    s_start = 1'b1; cycle(); s_start = 1'b0;
    hits = 0; np = 0;
    for (int k = 0; k < 400 && hits < 16; k++) begin
      if (s_moles != '0) begin
        h = 0;
        for (int i = NH - 1; i >= 0; i--) if (s_moles[i]) h = i;
        s_hit = HW'(h + 1); cycle();
        s_hit = '0; cycle();
        np += int'(s_mp | s_ep);
        if (s_hp) begin
          hits++;
          if (hits == 15) chk("sat_score15", int'(s_score), 15);
          if (hits == 16) chk("sat_score_hold", int'(s_score), 15);
        end
        cycle();
        np += int'(s_mp | s_ep);
      end else begin
        cycle();
        np += int'(s_mp | s_ep);
      end
    end
    chk("sat_hits", hits, 16);
    chk("sat_no_miss_escape", np, 0);
    chk("sat_running", int'(s_state == 2'd1 && s_time != '0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mole_field.md
MOLE_FIELD -- requirements
Module: mole_field

Interface
REQ-001 SHALL have parameter NUM_HOLES, default 5, number of mole holes (2..16).
REQ-002 SHALL have parameter TICK_CYCLES, default 50000000, clock cycles per game tick.
REQ-003 SHALL have parameter GAME_TICKS, default 30, game length in ticks.
REQ-004 SHALL have parameter SPAWN_TICKS, default 1, ticks between spawn attempts.
REQ-005 SHALL have parameter LIFE_TICKS, default 3, ticks a mole stays up.
REQ-006 SHALL have parameter SCORE_W, default 8, score width.
REQ-007 SHALL have port clock, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, level; a start request is accepted when high in IDLE or OVER.
REQ-010 SHALL have port hit_sel, input, HW=$clog2(NUM_HOLES+1), 0 = none, k = hole k-1.
REQ-011 SHALL have port moles, output, NUM_HOLES, bit i high = mole up in hole i.
REQ-012 SHALL have ports score (SCORE_W), time_left ($clog2(GAME_TICKS+1)), and state (2) as outputs.
REQ-013 SHALL have ports hit_pulse, miss_pulse, and escape_pulse as 1-bit outputs, each a single-cycle strobe.

Function
REQ-014 FSM states SHALL be IDLE=0, RUN=1, OVER=2; IDLE/OVER + start -> RUN; RUN + time_left reaching 0 -> OVER.
REQ-015 Entry to RUN SHALL clear score, moles, tick counter and spawn counter, and SHALL load time_left=GAME_TICKS.
REQ-016 In RUN, the tick counter SHALL count 0..TICK_CYCLES-1 and assert an internal tick on wrap.
REQ-017 Each tick SHALL decrement time_left; the tick that makes it 0 SHALL move the FSM to OVER on the same edge and clear moles.
REQ-018 A spawn attempt SHALL occur every SPAWN_TICKS ticks; hole = lfsr[7:0] mod NUM_HOLES; an occupied target SHALL produce no spawn.
REQ-019 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle in all states and never reseeded by start.
REQ-020 Each spawned mole SHALL load a lifetime of LIFE_TICKS and decrement per tick; on reaching 0 the mole SHALL be cleared and escape_pulse asserted.
REQ-021 hit_sel SHALL be registered once; a hit event SHALL occur when the registered value is nonzero and differs from its previous registered value, so holding hit_sel SHALL score once.
REQ-022 A hit event in RUN on an up mole SHALL clear that mole, increment score saturating at 2^SCORE_W-1, and assert hit_pulse, all on the same edge.
REQ-023 A hit event in RUN on an empty hole, or with hit_sel>NUM_HOLES, SHALL assert miss_pulse.
REQ-024 Hit events outside RUN SHALL be ignored and assert no pulse.
REQ-025 A hit and an expiry on the same hole in the same cycle SHALL count as a hit, with no escape_pulse.
REQ-026 A hit and a spawn targeting the same hole in the same cycle SHALL count the hit and suppress the spawn.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Asynchronous reset SHALL set: state IDLE, moles 0, score 0, time_left GAME_TICKS, all pulses 0, LFSR to its seed, all counters 0, hit_sel register 0.
REQ-029 Reset asserted mid-RUN SHALL abandon the game immediately, with no pulses on release.

Configuration
REQ-030 With MOLE_MISS_PENALTY_EN defined, each miss_pulse and each escape_pulse SHALL decrement score, saturating at 0; a hit and a penalty in the same cycle SHALL net to 0.
REQ-031 Without MOLE_MISS_PENALTY_EN, score SHALL never decrement, and pulses SHALL still be generated.

Structure
REQ-032 Shared package whack_pkg SHALL hold the FSM state encoding, LFSR seed/polynomial constants, and NUM_HOLES/SCORE_W defaults.
REQ-033 Per-hole lifetime logic SHALL be a sub-module mole_slot (up flag + lifetime counter; spawn/hit/tick in; up/escape out), instantiated NUM_HOLES times.

Verification
Bench parameters: TICK_CYCLES=4, GAME_TICKS=5, LIFE_TICKS=2, NUM_HOLES=5, SCORE_W=4.
REQ-034 Start pulse from IDLE -> state=1 and time_left=5; after 20 cycles state=2, time_left=0, moles=0.
REQ-035 Spawn into hole 2, then hit_sel=3 held for 10 cycles -> exactly one hit_pulse, score=1, moles[2]=0.
REQ-036 No hits for 2 ticks after a spawn -> escape_pulse once, mole cleared; score=0 with or without MOLE_MISS_PENALTY_EN.
REQ-037 Score forced to 15 via repeated hits, then another hit -> score stays 15; with the macro, a miss from score 0 -> score stays 0.
REQ-038 Hit landing on the expiry cycle -> hit_pulse=1, escape_pulse=0; reset mid-RUN -> state=0, score=0 in the same cycle.
